fpu_issue_arbiter: RTL
======================

FPU_ISSUE_ARBITER -- requirements
Module: fpu_issue_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing one FP16 execution datapath (2..8).
REQ-002 Parameter LAT, default 3: fixed datapath latency in cycles, issue to result (1..8).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 reqValid  input  NREQ  per-requester operation request.
REQ-006 reqReady  output  NREQ  per-requester accept; one-hot or zero.
REQ-007 reqOp  input  NREQ x 2  per-requester opcode: 0 ADD, 1 SUB, 2 MUL, 3 reserved.
REQ-008 reqA, reqB  input  NREQ x fp16_t  per-requester operands.
REQ-009 hold  input  1  blocks new grants; in-flight operations complete.
REQ-010 flush  input  1  discards all in-flight operations.
REQ-011 execValid  output  1  issue strobe to datapath.
REQ-012 execOp  output  2  issued opcode (0..2 only).
REQ-013 execA, execB  output  fp16_t  issued operands.
REQ-014 execResult  input  fp16_t  datapath result, valid LAT cycles after issue.
REQ-015 execFlags  input  statusFlag_t  datapath flags {NV,DZ,OF,UF,NX}, aligned with execResult.
REQ-016 rspValid  output  1  result return strobe; no backpressure.
REQ-017 rspId  output  clog2(NREQ)  requester index of returned result.
REQ-018 rspResult  output  fp16_t  returned result.
REQ-019 rspFlags  output  statusFlag_t  returned per-operation flags.
REQ-020 flagsClr  input  1  clears accumulated flags.
REQ-021 accFlags  output  statusFlag_t  sticky OR of all returned rspFlags.
REQ-022 busy  output  1  high while any operation is in flight.

Function
REQ-023 Arbitration SHALL be round-robin: grant the lowest index i, searching from pointer ptr upward with wrap, with reqValid[i]=1.
REQ-024 A grant SHALL occur only when hold=0 and flush=0; reqReady[grant]=1 that cycle, all other reqReady bits 0.
REQ-025 Handshake completes when reqValid[i] & reqReady[i]; requesters SHALL NOT make reqValid depend on reqReady.
REQ-026 After a grant to i, ptr SHALL become (i+1) mod NREQ; with no grant ptr SHALL be unchanged.
REQ-027 Grant of op 0..2 SHALL drive execValid=1, execOp, execA, execB combinationally in the same cycle; otherwise execValid=0.
REQ-028 Grant of op 3 SHALL NOT assert execValid; it SHALL occupy a tracking slot and return rspResult=16'h7E00, rspFlags=NV only.
REQ-029 In-flight tracking SHALL be an LAT-deep shift register of {valid, id, reserved}, advancing every cycle; at most one entry enters per cycle.
REQ-030 An operation issued in cycle t SHALL produce rspValid=1 in cycle t+LAT with rspId=its requester; back-to-back issues return back-to-back.
REQ-031 For non-reserved entries rspResult/rspFlags SHALL equal execResult/execFlags in the return cycle.
REQ-032 When rspValid=0, rspResult and rspFlags SHALL be 0.
REQ-033 flush SHALL clear all tracking entries in the same edge; no rspValid for operations issued before or during the flush cycle.
REQ-034 accFlags SHALL update as accFlags | rspFlags on each rspValid; flagsClr alone SHALL zero it; flagsClr with rspValid SHALL load rspFlags only.
REQ-035 busy SHALL be the OR of all tracking valid bits.
REQ-036 hold asserted mid-stream SHALL not affect in-flight entries; grants resume with ptr preserved.

Reset
REQ-037 On rst_n=0: ptr=0, tracking entries cleared, accFlags=0; reqReady, execValid, rspValid, busy SHALL read 0 while reset is asserted.
REQ-038 Reset asserted mid-operation SHALL drop all in-flight operations without any response after release.

Structure
REQ-039 fp16_t, statusFlag_t, FP16 width constants and an opcode enum (ADD, SUB, MUL, RSVD) SHALL live in the shared FPU package.
REQ-040 The round-robin grant logic SHALL be one sub-module, fpuRRArbiter (inputs request vector, pointer; outputs one-hot grant and index).

Verification
REQ-041 NREQ=4, LAT=3, reqValid=4'b1111 held 8 cycles -> grants 0,1,2,3,0,1,2,3; rspId sequence identical, starting 3 cycles after first grant.
REQ-042 reqValid=4'b0100 with ptr=3 -> grant 2, ptr becomes 3; next reqValid=4'b1001 -> grant 3 then 0.
REQ-043 Requester 1 issues op 3 -> execValid stays 0; 3 cycles later rspValid=1, rspId=1, rspResult=16'h7E00, rspFlags=5'b10000, accFlags NV set.
REQ-044 Three issues in consecutive cycles, flush on the cycle after the third -> no rspValid ever, busy=0 next cycle.
REQ-045 execFlags=NX on return with flagsClr same cycle while accFlags=OF -> accFlags=NX only.
REQ-046 rst_n pulsed low with 2 operations in flight -> all outputs 0 immediately, no responses after release, first post-reset grant to requester 0.

Source files
------------

// File: rtl/fpu_issue_arbiter_pkg.sv
// Shared FPU types: FP16 operand/result words, IEEE status flags and the opcode set
// used by the issue arbiter.
package fpu_issue_arbiter_pkg;

  localparam int unsigned Fp16Width = 16;
  localparam int unsigned FlagWidth = 5;

  typedef logic [Fp16Width-1:0] fp16_t;
  // Bit order {NV, DZ, OF, UF, NX}
  typedef logic [FlagWidth-1:0] statusFlag_t;

  localparam statusFlag_t FlagNv = 5'b10000;
  localparam statusFlag_t FlagDz = 5'b01000;
  localparam statusFlag_t FlagOf = 5'b00100;
  localparam statusFlag_t FlagUf = 5'b00010;
  localparam statusFlag_t FlagNx = 5'b00001;

  localparam fp16_t Fp16QNaN = 16'h7E00;

  typedef enum logic [1:0] {
    OpAdd  = 2'd0,
    OpSub  = 2'd1,
    OpMul  = 2'd2,
    OpRsvd = 2'd3
  } fpu_op_e;

endpackage

// File: rtl/fpu_issue_arbiter_rr.sv
// Round-robin grant: first asserted request found searching upward from ptr, with wrap.
module fpuRRArbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IdxW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IdxW-1:0] ptr,
  output logic [NREQ-1:0] grant,
  output logic [IdxW-1:0] idx
);

  logic        found;
  int unsigned pos;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    pos   = 0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      pos = 32'(ptr) + off;
      if (pos >= NREQ) pos = pos - NREQ;
      if (!found && req[IdxW'(pos)]) begin
        found              = 1'b1;
        grant[IdxW'(pos)]  = 1'b1;
        idx                = IdxW'(pos);
      end
    end
  end

endmodule

// File: rtl/fpu_issue_arbiter.sv
// Shares one fixed-latency FP16 datapath between NREQ requesters; tracks in-flight ops in a
// LAT-deep shift register and routes results and sticky flags back to the issuer.
module fpu_issue_arbiter
  import fpu_issue_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned LAT  = 3,
  localparam int unsigned IdxW = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        reqValid,
  output logic [NREQ-1:0]        reqReady,
  input  logic [NREQ-1:0][1:0]   reqOp,
  input  fp16_t [NREQ-1:0]       reqA,
  input  fp16_t [NREQ-1:0]       reqB,
  input  logic                   hold,
  input  logic                   flush,
  output logic                   execValid,
  output logic [1:0]             execOp,
  output fp16_t                  execA,
  output fp16_t                  execB,
  input  fp16_t                  execResult,
  input  statusFlag_t            execFlags,
  output logic                   rspValid,
  output logic [IdxW-1:0]        rspId,
  output fp16_t                  rspResult,
  output statusFlag_t            rspFlags,
  input  logic                   flagsClr,
  output statusFlag_t            accFlags,
  output logic                   busy
);

  logic [IdxW-1:0]           ptr_q, ptr_d, gnt_idx;
  logic [NREQ-1:0]           gnt_req, gnt;
  logic                      gnt_valid, gnt_rsvd;
  logic [LAT-1:0]            vld_q, vld_d, rsvd_q, rsvd_d;
  logic [LAT-1:0][IdxW-1:0]  id_q, id_d;
  statusFlag_t               acc_q, acc_d;

  // rst_n gates the request path so no handshake can complete while reset is held.
  assign gnt_req = reqValid & {NREQ{rst_n & ~hold & ~flush}};

  fpuRRArbiter #(
    .NREQ(NREQ),
    .IdxW(IdxW)
  ) u_arb (
    .req  (gnt_req),
    .ptr  (ptr_q),
    .grant(gnt),
    .idx  (gnt_idx)
  );

  assign gnt_valid = |gnt;
  assign gnt_rsvd  = gnt_valid & (fpu_op_e'(reqOp[gnt_idx]) == OpRsvd);
  assign reqReady  = gnt;
  assign execValid = gnt_valid & ~gnt_rsvd;
  assign execOp    = execValid ? reqOp[gnt_idx] : '0;
  assign execA     = execValid ? reqA[gnt_idx] : '0;
  assign execB     = execValid ? reqB[gnt_idx] : '0;

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_valid) ptr_d = (gnt_idx == IdxW'(NREQ - 1)) ? '0 : gnt_idx + IdxW'(1);
  end

  always_comb begin
    vld_d  = '0;
    rsvd_d = '0;
    id_d   = id_q;
    if (!flush) begin
      vld_d[0]  = gnt_valid;
      rsvd_d[0] = gnt_rsvd;
      id_d[0]   = gnt_idx;
      for (int i = 1; i < int'(LAT); i++) begin
        vld_d[i]  = vld_q[i-1];
        rsvd_d[i] = rsvd_q[i-1];
        id_d[i]   = id_q[i-1];
      end
    end
  end

  // An op reaching the tail in the flush cycle is discarded too.
  assign rspValid  = vld_q[LAT-1] & ~flush;
  assign rspId     = rspValid ? id_q[LAT-1] : '0;
  assign rspResult = rspValid ? (rsvd_q[LAT-1] ? Fp16QNaN : execResult) : '0;
  assign rspFlags  = rspValid ? (rsvd_q[LAT-1] ? FlagNv : execFlags) : '0;
  assign busy      = |vld_q;
  assign accFlags  = acc_q;

  // rspFlags is zero without a response, so a lone clear loads zero.
  always_comb begin
    acc_d = acc_q;
    if (flagsClr)      acc_d = rspFlags;
    else if (rspValid) acc_d = acc_q | rspFlags;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q  <= '0;
      vld_q  <= '0;
      rsvd_q <= '0;
      id_q   <= '0;
      acc_q  <= '0;
    end else begin
      ptr_q  <= ptr_d;
      vld_q  <= vld_d;
      rsvd_q <= rsvd_d;
      id_q   <= id_d;
      acc_q  <= acc_d;
    end
  end

endmodule
